// File: rtl/m_dram_arbiter_if.sv
// m_dram_arbiter_if: requester and DRAM-controller signals of the shared DRAM port.
interface m_dram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [2:0]        i_req;
   logic [ADDR_W-1:0] i_ptw_addr;
   logic [ADDR_W-1:0] i_ins_addr;
   logic [ADDR_W-1:0] i_dat_addr;
   logic              i_ptw_we;
   logic              i_dat_we;
   logic [DATA_W-1:0] i_ptw_wdata;
   logic [DATA_W-1:0] i_dat_wdata;
   logic [3:0]        i_dat_be;
   logic              o_dram_le;
   logic              o_dram_we;
   logic [ADDR_W-1:0] o_dram_addr;
   logic [DATA_W-1:0] o_dram_wdata;
   logic [3:0]        o_dram_be;
   logic              i_dram_busy;
   logic [DATA_W-1:0] i_dram_rdata;
   logic [2:0]        o_grant;
   logic [2:0]        o_done;
   logic [DATA_W-1:0] o_rdata;
   logic              o_err;
   logic              o_busy;
   modport slave (
      input  i_req, i_ptw_addr, i_ins_addr, i_dat_addr, i_ptw_we, i_dat_we,
             i_ptw_wdata, i_dat_wdata, i_dat_be, i_dram_busy, i_dram_rdata,
      output o_dram_le, o_dram_we, o_dram_addr, o_dram_wdata, o_dram_be,
             o_grant, o_done, o_rdata, o_err, o_busy
   );
   modport master (
      output i_req, i_ptw_addr, i_ins_addr, i_dat_addr, i_ptw_we, i_dat_we,
             i_ptw_wdata, i_dat_wdata, i_dat_be, i_dram_busy, i_dram_rdata,
      input  o_dram_le, o_dram_we, o_dram_addr, o_dram_wdata, o_dram_be,
             o_grant, o_done, o_rdata, o_err, o_busy
   );
endinterface

// File: rtl/m_dram_arbiter.sv
// m_dram_arbiter: serialises PTW/instruction/data accesses onto one DRAM port,
// one strobe at a time, with a watchdog that aborts transactions stuck on busy.
module m_dram_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 4095,
   parameter int TO_W    = 12
) (
   input logic CLK,
   input logic RST_X,
   m_dram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t            state, state_nx;
   logic [2:0]        grant, win;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata, rdata;
   logic [3:0]        be;
   logic              we, err, rr, timeout;
   logic [TO_W-1:0]   wdog;
   // PTW always wins; rr breaks the instruction/data tie
   assign win = bus.i_req[0] ? 3'b001 :
                (bus.i_req[1] && (!rr || !bus.i_req[2])) ? 3'b010 :
                bus.i_req[2] ? 3'b100 : 3'b000;
   assign timeout = wdog == TO_W'(TIMEOUT);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (bus.i_req != 3'b000 && !bus.i_dram_busy) ? ISSUE : IDLE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = (!bus.i_dram_busy || timeout) ? RESP : WAIT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RST_X)
      if (!RST_X) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         grant <= '0;
         addr  <= '0;
         we    <= 1'b0;
         wdata <= '0;
         be    <= '0;
         rdata <= '0;
         err   <= 1'b0;
         rr    <= 1'b0;
         wdog  <= '0;
      end else begin
         case (state)
            IDLE: if (state_nx == ISSUE) begin
               grant <= win;
               addr  <= win[0] ? bus.i_ptw_addr : win[1] ? bus.i_ins_addr : bus.i_dat_addr;
               we    <= win[0] ? bus.i_ptw_we : win[2] & bus.i_dat_we;
               wdata <= win[0] ? bus.i_ptw_wdata : win[2] ? bus.i_dat_wdata : '0;
               be    <= win[2] ? bus.i_dat_be : 4'hF;
            end
            ISSUE: wdog <= '0;
            WAIT:
               if (!bus.i_dram_busy) rdata <= we ? '0 : bus.i_dram_rdata;
               else if (timeout) begin
                  err   <= 1'b1;
                  rdata <= '0;
               end else wdog <= wdog + 1'b1;
            default: begin
               rr    <= grant[1] | (rr & ~grant[2]);
               grant <= '0;
               err   <= 1'b0;
               addr  <= '0;
               we    <= 1'b0;
               wdata <= '0;
               be    <= '0;
               rdata <= '0;
            end
         endcase
      end
   end
   // latches are cleared on leaving RESP, so the bus reads 0 while idle
   assign bus.o_dram_le    = state == ISSUE && !we;
   assign bus.o_dram_we    = state == ISSUE && we;
   assign bus.o_dram_addr  = addr;
   assign bus.o_dram_wdata = wdata;
   assign bus.o_dram_be    = be;
   assign bus.o_grant      = grant;
   assign bus.o_done       = state == RESP ? grant : 3'b000;
   assign bus.o_rdata      = rdata;
   assign bus.o_err        = err;
   assign bus.o_busy       = state != IDLE;
endmodule

// File: tb/tb_m_dram_arbiter.sv
// tb_m_dram_arbiter: directed and randomized checks of m_dram_arbiter against a
// simple DRAM responder and a transaction-level arbitration model.
module tb_m_dram_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   m_dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
   m_dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(4)) dut (
      .CLK(clk), .RST_X(rst_n), .bus(bus.slave));
   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int lat = 1;
   int cnt = 0;
   logic ext_busy = 1'b0, stuck = 1'b0, stuck_act = 1'b0, use_fixed = 1'b0;
   logic [31:0] fixed_val = '0, rd_q = '0;
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction
   // DRAM controller model: busy for lat cycles starting the cycle after a strobe
   initial begin
      logic b;
      bus.i_dram_busy = 1'b0;
      bus.i_dram_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!stuck) stuck_act = 1'b0;
         if (!rst_n) begin
            cnt = 0;
            stuck_act = 1'b0;
         end
         b = ext_busy || stuck_act || cnt > 0;
         if (cnt > 0) cnt--;
         if (rst_n && (bus.o_dram_le || bus.o_dram_we)) begin
            cnt = lat;
            stuck_act = stuck;
            rd_q = use_fixed ? fixed_val : mem(bus.o_dram_addr);
         end
         bus.i_dram_busy = b;
         bus.i_dram_rdata = b ? $urandom : rd_q;
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_inputs();
      bus.i_req = '0;
      bus.i_ptw_addr = '0;
      bus.i_ins_addr = '0;
      bus.i_dat_addr = '0;
      bus.i_ptw_we = 1'b0;
      bus.i_dat_we = 1'b0;
      bus.i_ptw_wdata = '0;
      bus.i_dat_wdata = '0;
      bus.i_dat_be = 4'hF;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask
   task automatic wait_strobe(input string nm, output bit ok);
      int n = 0;
      while (!(bus.o_dram_le || bus.o_dram_we) && n < 40) begin
         step();
         n++;
      end
      ok = bus.o_dram_le || bus.o_dram_we;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s: no strobe within 40 cycles", nm);
      end
   endtask
   task automatic wait_done(input string nm, output bit ok);
      int n = 0;
      while (bus.o_done == 3'b000 && n < 40) begin
         step();
         n++;
      end
      ok = bus.o_done != 3'b000;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s: no done within 40 cycles", nm);
      end
   endtask
   task automatic test_reset();
      logic [108:0] outs;
      rst_n = 1'b0;
      clear_inputs();
      repeat (3) step();
      outs = {bus.o_dram_le, bus.o_dram_we, bus.o_dram_addr, bus.o_dram_wdata, bus.o_dram_be,
              bus.o_grant, bus.o_done, bus.o_rdata, bus.o_err, bus.o_busy};
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      rst_n = 1'b1;
      step();
      total++;
      if (bus.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: o_busy got %b expected 0", bus.o_busy);
      end
   endtask
   task automatic test_single_read();
      use_fixed = 1'b1;
      fixed_val = 32'hDEAD_BEEF;
      lat = 3;
      bus.i_ins_addr = 32'h8000_1000;
      bus.i_req = 3'b010;
      for (int k = 1; k <= 6; k++) begin
         step();
         total++;
         if (k == 1) begin
            if ({bus.o_dram_le, bus.o_dram_we, bus.o_dram_addr, bus.o_grant} !== {2'b10, 32'h8000_1000, 3'b010}) begin
               bad++;
               $display("FAIL single_strobe: le=%b we=%b addr=%h grant=%b expected le=1 we=0 addr=80001000 grant=010",
                        bus.o_dram_le, bus.o_dram_we, bus.o_dram_addr, bus.o_grant);
            end
         end else if (k < 6) begin
            if ({bus.o_dram_le, bus.o_dram_we, bus.o_done} !== 5'b0) begin
               bad++;
               $display("FAIL single_wait%0d: le=%b we=%b done=%b expected all 0", k, bus.o_dram_le, bus.o_dram_we, bus.o_done);
            end
         end else if ({bus.o_done, bus.o_rdata, bus.o_err} !== {3'b010, 32'hDEAD_BEEF, 1'b0}) begin
            bad++;
            $display("FAIL single_done: done=%b rdata=%h err=%b expected 010 deadbeef 0", bus.o_done, bus.o_rdata, bus.o_err);
         end
      end
      bus.i_req = 3'b000;
      use_fixed = 1'b0;
      step();
   endtask
   task automatic test_all_three();
      logic [2:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b010};
      logic [31:0] exp_addr [4] = '{32'h100, 32'h200, 32'h300, 32'h200};
      logic [2:0] d;
      bit ok;
      do_reset();
      bus.i_ptw_addr = 32'h100;
      bus.i_ins_addr = 32'h200;
      bus.i_dat_addr = 32'h300;
      bus.i_req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         lat = $urandom_range(1, 3);
         wait_done("all3", ok);
         if (!ok) break;
         d = bus.o_done;
         total++;
         if (d !== exp_seq[k] || bus.o_grant !== exp_seq[k] || $countones(bus.o_grant) != 1 || bus.o_rdata !== mem(exp_addr[k])) begin
            bad++;
            $display("FAIL all3_order%0d: done=%b grant=%b rdata=%h expected %b %b %h",
                     k, d, bus.o_grant, bus.o_rdata, exp_seq[k], exp_seq[k], mem(exp_addr[k]));
         end
         bus.i_req = bus.i_req & ~d;
         step();
         if (d != 3'b001) bus.i_req = bus.i_req | d;
      end
      bus.i_req = 3'b000;
      repeat (2) step();
   endtask
   task automatic test_ptw_write();
      bit ok;
      lat = 2;
      bus.i_ptw_addr = 32'h0010_0404;
      bus.i_ptw_wdata = 32'h2000_00CF;
      bus.i_ptw_we = 1'b1;
      bus.i_req = 3'b001;
      wait_strobe("ptw_write", ok);
      if (ok) begin
         total++;
         if ({bus.o_dram_le, bus.o_dram_we, bus.o_dram_addr, bus.o_dram_wdata, bus.o_dram_be} !==
             {2'b01, 32'h0010_0404, 32'h2000_00CF, 4'hF}) begin
            bad++;
            $display("FAIL ptw_write_strobe: le=%b we=%b addr=%h wdata=%h be=%h expected 0 1 00100404 200000cf f",
                     bus.o_dram_le, bus.o_dram_we, bus.o_dram_addr, bus.o_dram_wdata, bus.o_dram_be);
         end
         step();
         total++;
         if (bus.o_dram_we !== 1'b0) begin
            bad++;
            $display("FAIL ptw_write_pulse: we got %b expected 0 one cycle after strobe", bus.o_dram_we);
         end
         wait_done("ptw_write", ok);
         if (ok) begin
            total++;
            if ({bus.o_done, bus.o_rdata, bus.o_err} !== {3'b001, 32'h0, 1'b0}) begin
               bad++;
               $display("FAIL ptw_write_done: done=%b rdata=%h err=%b expected 001 0 0", bus.o_done, bus.o_rdata, bus.o_err);
            end
         end
      end
      bus.i_req = 3'b000;
      bus.i_ptw_we = 1'b0;
      step();
   endtask
   task automatic test_busy_at_request();
      bit ok;
      ext_busy = 1'b1;
      step();
      lat = 1;
      bus.i_dat_addr = 32'h0000_4444;
      bus.i_dat_we = 1'b0;
      bus.i_req = 3'b100;
      for (int k = 0; k < 5; k++) begin
         step();
         total++;
         if ({bus.o_dram_le, bus.o_dram_we, bus.o_busy} !== 3'b000) begin
            bad++;
            $display("FAIL busy_hold%0d: le=%b we=%b busy=%b expected 000", k, bus.o_dram_le, bus.o_dram_we, bus.o_busy);
         end
      end
      ext_busy = 1'b0;
      step();
      total++;
      if (bus.o_dram_le !== 1'b1) begin
         bad++;
         $display("FAIL busy_release: le got %b expected 1 one cycle after busy falls", bus.o_dram_le);
      end
      wait_done("busy_release", ok);
      if (ok) begin
         total++;
         if ({bus.o_done, bus.o_rdata} !== {3'b100, mem(32'h0000_4444)}) begin
            bad++;
            $display("FAIL busy_done: done=%b rdata=%h expected 100 %h", bus.o_done, bus.o_rdata, mem(32'h0000_4444));
         end
      end
      bus.i_req = 3'b000;
      step();
   endtask
   task automatic test_watchdog();
      bit ok;
      int s;
      stuck = 1'b1;
      bus.i_ins_addr = 32'h0000_0A00;
      bus.i_req = 3'b010;
      wait_strobe("watchdog", ok);
      s = cyc;
      if (ok) begin
         wait_done("watchdog", ok);
         if (ok) begin
            total++;
            if (cyc - s != TO + 2 || {bus.o_done, bus.o_err, bus.o_rdata} !== {3'b010, 1'b1, 32'h0}) begin
               bad++;
               $display("FAIL watchdog_abort: delay=%0d done=%b err=%b rdata=%h expected %0d 010 1 0",
                        cyc - s, bus.o_done, bus.o_err, bus.o_rdata, TO + 2);
            end
         end
      end
      bus.i_req = 3'b000;
      stuck = 1'b0;
      step();
      lat = 2;
      bus.i_dat_addr = 32'h0000_0B00;
      bus.i_req = 3'b100;
      wait_done("watchdog_next", ok);
      if (ok) begin
         total++;
         if ({bus.o_done, bus.o_err, bus.o_rdata} !== {3'b100, 1'b0, mem(32'h0000_0B00)}) begin
            bad++;
            $display("FAIL watchdog_next: done=%b err=%b rdata=%h expected 100 0 %h",
                     bus.o_done, bus.o_err, bus.o_rdata, mem(32'h0000_0B00));
         end
      end
      bus.i_req = 3'b000;
      step();
   endtask
   task automatic test_reset_midop();
      bit ok;
      lat = 1;
      bus.i_ins_addr = 32'h0000_1100;
      bus.i_req = 3'b010;
      wait_done("midop_pre", ok);
      bus.i_req = 3'b000;
      step();
      lat = 6;
      bus.i_dat_addr = 32'h0000_2200;
      bus.i_req = 3'b100;
      wait_strobe("midop", ok);
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.o_busy, bus.o_grant, bus.o_done, bus.o_dram_addr, bus.o_dram_le, bus.o_dram_we, bus.o_err} !== '0) begin
         bad++;
         $display("FAIL midop_reset: busy=%b grant=%b done=%b addr=%h expected all 0",
                  bus.o_busy, bus.o_grant, bus.o_done, bus.o_dram_addr);
      end
      bus.i_req = 3'b000;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (bus.o_done !== 3'b000) begin
            bad++;
            $display("FAIL midop_nodone%0d: done got %b expected 000", k, bus.o_done);
         end
      end
      rst_n = 1'b1;
      bus.i_req = 3'b110;
      wait_strobe("midop_after", ok);
      if (ok) begin
         total++;
         if (bus.o_grant !== 3'b010 || bus.o_dram_addr !== 32'h0000_1100) begin
            bad++;
            $display("FAIL midop_tie: grant=%b addr=%h expected 010 00001100", bus.o_grant, bus.o_dram_addr);
         end
      end
      bus.i_req = 3'b000;
      wait_done("midop_after", ok);
      step();
   endtask
   logic [2:0]  pend;
   logic [31:0] m_addr [3];
   logic [31:0] m_wd [3];
   logic        m_we [3];
   logic [3:0]  m_be [3];
   task automatic arm(input int r);
      pend[r] = 1'b1;
      m_addr[r] = $urandom;
      m_wd[r] = $urandom;
      m_we[r] = r != 1 && $urandom_range(0, 1) == 1;
      m_be[r] = r == 2 ? 4'($urandom_range(1, 15)) : 4'hF;
      if (r == 0) begin
         bus.i_ptw_addr = m_addr[0];
         bus.i_ptw_we = m_we[0];
         bus.i_ptw_wdata = m_wd[0];
      end else if (r == 1) bus.i_ins_addr = m_addr[1];
      else begin
         bus.i_dat_addr = m_addr[2];
         bus.i_dat_we = m_we[2];
         bus.i_dat_wdata = m_wd[2];
         bus.i_dat_be = m_be[2];
      end
      bus.i_req[r] = 1'b1;
   endtask
   // transaction-level model: PTW first, then the side the round-robin bit favours
   function automatic int pick(input logic [2:0] p, input logic rrm);
      if (p[0]) return 0;
      if (p[1] && p[2]) return rrm ? 2 : 1;
      return p[1] ? 1 : 2;
   endfunction
   task automatic test_random();
      logic rr_m = 1'b0;
      int w, s;
      bit ok;
      logic [31:0] exp_rd;
      do_reset();
      pend = '0;
      arm($urandom_range(0, 2));
      for (int r = 0; r < 3; r++) if (!pend[r] && $urandom_range(0, 1) == 1) arm(r);
      for (int t = 0; t < 40; t++) begin
         w = pick(pend, rr_m);
         lat = $urandom_range(1, 4);
         wait_strobe("rand", ok);
         if (!ok) break;
         s = cyc;
         total++;
         if (bus.o_grant !== 3'(1 << w) || bus.o_dram_we !== m_we[w] || bus.o_dram_le !== !m_we[w] ||
             bus.o_dram_addr !== m_addr[w] || (m_we[w] && bus.o_dram_wdata !== m_wd[w]) ||
             (w != 1 && bus.o_dram_be !== m_be[w])) begin
            bad++;
            $display("FAIL rand_strobe%0d: grant=%b le=%b we=%b addr=%h wdata=%h be=%h expected grant=%b we=%b addr=%h wdata=%h be=%h",
                     t, bus.o_grant, bus.o_dram_le, bus.o_dram_we, bus.o_dram_addr, bus.o_dram_wdata, bus.o_dram_be,
                     3'(1 << w), m_we[w], m_addr[w], m_wd[w], m_be[w]);
         end
         wait_done("rand", ok);
         if (!ok) break;
         exp_rd = m_we[w] ? 32'h0 : mem(m_addr[w]);
         total++;
         if (cyc - s != lat + 2 || bus.o_done !== 3'(1 << w) || bus.o_rdata !== exp_rd || bus.o_err !== 1'b0) begin
            bad++;
            $display("FAIL rand_done%0d: delay=%0d done=%b rdata=%h err=%b expected %0d %b %h 0",
                     t, cyc - s, bus.o_done, bus.o_rdata, bus.o_err, lat + 2, 3'(1 << w), exp_rd);
         end
         if (w == 1) rr_m = 1'b1;
         if (w == 2) rr_m = 1'b0;
         pend[w] = 1'b0;
         bus.i_req[w] = 1'b0;
         for (int r = 0; r < 3; r++) if (r != w && !pend[r] && $urandom_range(0, 2) != 0) arm(r);
         if (pend == 3'b000) arm((w + $urandom_range(1, 2)) % 3);
         step();
      end
      bus.i_req = 3'b000;
      repeat (12) step();
   endtask
   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_all_three();
      test_ptw_write();
      test_busy_at_request();
      test_watchdog();
      test_reset_midop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
